cacheline_adaptor: RTL and testbench

Converts the 256-bit single-transfer physical-memory port of `mp2` (`pmem_*`) into a 64-bit, 4-beat burst protocol for the off-chip DRAM model. It sits directly downstream of `mp2`: the `mp2` pmem outputs drive its line-side inputs, and its burst side connects to the memory model. Each line read or write becomes exactly one 4-beat burst. The block tracks beats with a small FSM and beat counter, and returns a single-cycle `resp_o` to `mp2`.

---
 rtl/rv32i_types.sv | 20 ++
 rtl/cacheline_adaptor.sv | 83 ++++++++
 tb/tb_cacheline_adaptor.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types: the burst-side constants and the cacheline adaptor state encoding.
package rv32i_types;

  localparam int unsigned BURST_W  = 64;
  localparam int unsigned BEATS    = 4;
  localparam int unsigned LINE_W   = BURST_W * BEATS;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned OFFSET_W = $clog2(LINE_W / 8);
  localparam int unsigned CNT_W    = $clog2(BEATS);

  typedef logic [BURST_W-1:0] rv32i_burst;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } cla_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Splits a 256-bit line transfer from mp2 into a 4-beat, 64-bit little-endian
// burst to the DRAM model, and returns a one-cycle completion pulse.
module cacheline_adaptor
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  rv32i_burst        burst_i,
  output rv32i_burst        burst_o,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  cla_state_t                      state;
  logic [CNT_W-1:0]                cnt;
  logic [BEATS-1:0][BURST_W-1:0]   buffer;
  logic [ADDR_W-1:0]               addr_q;
  logic [ADDR_W-1:0]               addr_aligned;
  logic                            is_last;
  logic                            unused_offset_bits;

  assign addr_aligned       = {address_i[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
  assign is_last            = (cnt == CNT_W'(BEATS - 1));
  // Line offset bits are dropped by alignment.
  assign unused_offset_bits = ^address_i[OFFSET_W-1:0];

  // State, beat counter, line buffer and burst address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      buffer <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i) begin
            buffer <= line_i;
            addr_q <= addr_aligned;
            cnt    <= '0;
            state  <= WR;
          end else if (read_i) begin
            addr_q <= addr_aligned;
            cnt    <= '0;
            state  <= RD;
          end
        end
        RD: begin
          if (resp_i) begin
            buffer[cnt] <= burst_i;
            cnt         <= cnt + CNT_W'(1);
            if (is_last) state <= DONE;
          end
        end
        WR: begin
          if (resp_i) begin
            cnt <= cnt + CNT_W'(1);
            if (is_last) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the registered state.
  assign read_o    = (state == RD);
  assign write_o   = (state == WR);
  assign resp_o    = (state == DONE);
  assign line_o    = buffer;
  assign address_o = addr_q;
  assign burst_o   = (state == WR) ? buffer[cnt] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: expected lines, beats and addresses are
// queued when a request is driven and retired as the DUT produces them.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_chk = 0;
  int n_err = 0;

  logic [255:0] line_q[$];
  logic [63:0]  beat_q[$];
  logic [31:0]  addr_q[$];

  cacheline_adaptor dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs and samples happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_read_o"},  read_o,  1'b0);
    check({tag, "_write_o"}, write_o, 1'b0);
    check({tag, "_resp_o"},  resp_o,  1'b0);
  endtask

  // Wait (bounded) for resp_o; it must appear in the current cycle.
  task automatic wait_resp(input string tag, output bit seen);
    int w = 0;
    while (!resp_o && w < 8) begin
      step();
      w++;
    end
    check({tag, "_resp_delay"}, 256'(w), 256'(0));
    seen = resp_o;
    if (!seen) check({tag, "_resp_timeout"}, 256'(0), 256'(1));
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [255:0] data, input bit [15:0] pattern);
    int k = 0;
    int cyc = 0;
    bit seen;
    logic [63:0] chunk;
    line_q.push_back(data);
    addr_q.push_back({addr[31:5], 5'b0});
    read_i    = 1'b1;
    write_i   = 1'b0;
    address_i = addr;
    step();
    check({tag, "_addr_o"}, address_o, addr_q[0]);
    while (k < 4 && cyc < 40) begin
      check({tag, "_read_o"},  read_o,  1'b1);
      check({tag, "_write_o"}, write_o, 1'b0);
      resp_i = (cyc < 16) ? pattern[cyc] : 1'b1;
      chunk  = data[64*k +: 64];
      burst_i = resp_i ? chunk : 64'($urandom()) << 32 | 64'($urandom());
      if (resp_i) k++;
      step();
      cyc++;
    end
    resp_i  = 1'b0;
    burst_i = '0;
    wait_resp(tag, seen);
    if (seen) begin
      check({tag, "_line_o"},   line_o,    line_q.pop_front());
      check({tag, "_addr_done"}, address_o, addr_q.pop_front());
      check({tag, "_read_drop"}, read_o,    1'b0);
    end
    read_i = 1'b0;
    step();
    check_idle_outputs({tag, "_after"});
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [255:0] line,
                          input bit [15:0] pattern, input bit also_read);
    int cyc = 0;
    bit seen;
    for (int b = 0; b < 4; b++) beat_q.push_back(line[64*b +: 64]);
    addr_q.push_back({addr[31:5], 5'b0});
    write_i   = 1'b1;
    read_i    = also_read;
    address_i = addr;
    line_i    = line;
    step();
    line_i = ~line;
    check({tag, "_addr_o"}, address_o, addr_q[0]);
    while (beat_q.size() > 0 && cyc < 40) begin
      check({tag, "_write_o"}, write_o, 1'b1);
      check({tag, "_read_o"},  read_o,  1'b0);
      check({tag, "_burst_o"}, burst_o, beat_q[0]);
      resp_i = (cyc < 16) ? pattern[cyc] : 1'b1;
      if (resp_i) void'(beat_q.pop_front());
      step();
      cyc++;
    end
    resp_i = 1'b0;
    wait_resp(tag, seen);
    if (seen) begin
      check({tag, "_addr_done"},  address_o, addr_q.pop_front());
      check({tag, "_write_drop"}, write_o,   1'b0);
    end
    write_i = 1'b0;
    read_i  = 1'b0;
    step();
    check_idle_outputs({tag, "_after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] rd_line;
    logic [255:0] wr_line;
    logic [255:0] line2;

    reset_n   = 1'b0;
    read_i    = 1'b1;
    write_i   = 1'b0;
    address_i = 32'h0000_1234;
    line_i    = '0;
    burst_i   = '0;
    resp_i    = 1'b0;

    // Reset held for two cycles with a read pending.
    for (int i = 0; i < 2; i++) begin
      step();
      check_idle_outputs("rst");
      check("rst_line_o",  line_o,    256'(0));
      check("rst_burst_o", burst_o,   256'(0));
      check("rst_addr_o",  address_o, 256'(0));
    end
    reset_n = 1'b1;
    check("rst_release_read_o", read_o, 1'b0);
    step();
    check("rst_after_read_o", read_o, 1'b1);
    reset_n = 1'b0;
    read_i  = 1'b0;
    step();
    check_idle_outputs("rst2");
    reset_n = 1'b1;
    step();

    // Contiguous read.
    rd_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read("rd", 32'h0000_1234, rd_line, 16'hffff);
    check("rd_align", 256'(32'h0000_1220), 256'({32'h0000_1234 >> 5, 5'b0}));

    // Write with gapped beat strobes 1,0,0,1,1,0,1.
    wr_line = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
    do_write("wr", 32'hdead_beef, wr_line, 16'b0000_0000_0101_1001, 1'b0);

    // Simultaneous read and write requests: write wins.
    do_write("wr_prio", 32'h8000_0040, ~wr_line, 16'hffff, 1'b1);

    // Reset after two read beats aborts the burst.
    read_i    = 1'b1;
    address_i = 32'h0000_0100;
    step();
    for (int b = 0; b < 2; b++) begin
      resp_i  = 1'b1;
      burst_i = 64'haaaa_0000_0000_0000 | 64'(b);
      step();
    end
    resp_i  = 1'b0;
    reset_n = 1'b0;
    read_i  = 1'b0;
    step();
    check_idle_outputs("abort");
    check("abort_line_o", line_o,    256'(0));
    check("abort_addr_o", address_o, 256'(0));
    reset_n = 1'b1;
    step();
    check("abort_no_resp", resp_o, 1'b0);
    line2 = {64'hcafe_0003_0003_0003, 64'hcafe_0002_0002_0002,
             64'hcafe_0001_0001_0001, 64'hcafe_0000_0000_0000};
    do_read("rd_post_abort", 32'h0000_0100, line2, 16'b0000_0000_0010_1101);

    // Spurious beats in IDLE must not be captured.
    for (int i = 0; i < 3; i++) begin
      resp_i  = 1'b1;
      burst_i = 64'hbad0_bad0_bad0_0000 | 64'(i);
      step();
      check_idle_outputs("spur");
    end
    resp_i = 1'b0;
    do_read("rd_spur", 32'hffff_ffff, rd_line ^ line2, 16'hffff);

    check("sb_lines_empty", 256'(line_q.size()), 256'(0));
    check("sb_beats_empty", 256'(beat_q.size()), 256'(0));
    check("sb_addr_empty",  256'(addr_q.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
